rr_priority_encoder: RTL and testbench
======================================

# rr_priority_encoder

Parametrised, registered N-to-log2(N) priority encoder and the successor to the combinational 8-to-3 encoder. It reduces a request vector to a single granted index, with either fixed or round-robin priority. The result is held in an output register behind a valid/ready handshake. It sits between request sources (interrupt lines, channel requests) and a single downstream consumer that may stall.

## Interface
- `N`, default 8: number of request lines; legal range 2..256, not required to be a power of two.
- `MODE`, default 0: priority scheme.
  - 0: fixed priority, highest index wins.
  - 1: round-robin, rotating pointer.
- `W`, derived localparam, not overridable: `$clog2(N)`.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N  request vector, level-sensitive, sampled only when the output slot loads.
- `out_ready`  in  1  consumer accepts the current result.
- `out_valid`  out  1  output register holds a result.
- `out_index`  out  W  binary index of the granted request.
- `out_onehot`  out  N  one-hot form of `out_index`; all-zero when `out_valid`=0.
- `out_multi`  out  1  more than one `req` bit was set when the result loaded.

## Operation
- The output slot loads when `load = !out_valid || out_ready`.
- **Load behaviour**, when `load`=1:
  - `|req`=1: `out_valid`←1; `out_index`←selected index; `out_onehot`←1<<index; `out_multi`←(popcount(req)>1).
  - `|req`=0: `out_valid`←0; `out_index`←0; `out_onehot`←0; `out_multi`←0.
- **Hold behaviour**, when `load`=0: all outputs hold and `req` is ignored. The output is stable under backpressure.
- **MODE=0 selection**: highest set bit of `req`, e.g. 8'hFF→7.
- **MODE=1 selection**:
  - Internal pointer `ptr` (W bits, range 0..N-1).
  - Scan `req` from index `ptr` upward, wrapping past N-1 to 0. The first set bit wins.
- **MODE=1 pointer update**:
  - On handshake (`out_valid && out_ready`), `ptr`←`out_index`+1.
  - The pointer wraps to 0 when `out_index`=N-1. For non-power-of-two N, it never takes values ≥N.
  - `ptr` changes only on a handshake; a load that follows an empty slot does not move it.
- **Pointer use in a handshake cycle**: the new load uses the post-handshake pointer, `out_index`+1. The pointer update and the next selection are computed combinationally in the same cycle.
- **MODE=0**: `ptr` is absent or unused; no rotation.
- **`out_index` range**: always < N.
- **Reset**: `rst`=1 forces `out_valid`=0, `out_index`=0, `out_onehot`=0, `out_multi`=0, `ptr`=0. Reset has priority over load and handshake, including mid-stall.

## Timing
- **Latency**: one cycle from `req` sampled (load cycle) to `out_valid`/`out_index` visible.
- **Throughput**: one result per cycle with `out_ready` held high.
- **Pending result**: while `out_valid`=1 and `out_ready`=0, outputs are frozen indefinitely. A `req` change during the stall is not seen until the cycle `out_ready`=1.
- **Handshake and request change in the same cycle**: the completing result is consumed. The slot reloads from the current `req` at that edge, with no bubble.
- **Request drop**: `req` going to zero with the slot free gives `out_valid`=0 on the next edge. There is no timeout or hold-over.
- **First cycle after reset release**: the slot is empty, so the first edge with `rst`=0 loads from `req`.
- **Combinational paths**: none from inputs to outputs; all outputs are registered.

## Test plan
1. **Reset**: drive `rst`=1 for 2 cycles with `req`=8'hFF and `out_ready`=1 → `out_valid`=0, `out_index`=0, `out_onehot`=0, `out_multi`=0 throughout. After release, the next edge gives `out_valid`=1 and `out_index`=7.
2. **MODE=0 walking one, then all-ones**:
   - `req`=8'h00, 01, 02, 04 … 80, FF, one per cycle, `out_ready`=1 → one cycle later `out_valid`=0 for 00.
   - Indices 0..7 with `out_onehot` equal to `req` and `out_multi`=0.
   - For FF: `out_index`=7, `out_onehot`=8'h80, `out_multi`=1.
3. **Backpressure**:
   - MODE=0, `req`=8'h08, `out_ready`=0 → `out_index`=3 and `out_valid`=1 held.
   - Change `req` to 8'h10 for 5 cycles → outputs unchanged.
   - Raise `out_ready` → next edge `out_index`=4.
4. **MODE=1 rotation**: `req`=8'hFF held, `out_ready`=1 → `out_index` sequence 0,1,2,…,7,0,1 on successive cycles, `out_multi`=1 each.
5. **MODE=1 wrap and sparse requests**:
   - `req`=8'h81, `out_ready`=1 → grants alternate 0,7,0,7.
   - Then `req`=8'h00 → `out_valid`=0.
   - Then `req`=8'h02 → `out_index`=1, since `ptr` is unchanged while empty.
   - Repeat with N=5, `req`=5'b11111 → 0,1,2,3,4,0.
6. **Reset mid-stall**: MODE=1, `ptr` advanced to 5, `out_valid`=1, `out_ready`=0, then pulse `rst` → all outputs clear. After release with `req`=8'hFF, `out_index`=0, confirming `ptr` reset to 0.

Source files
------------

// File: rtl/rr_priority_encoder_if.sv
// Request/result bundle for rr_priority_encoder: request vector in, registered grant out.
// The master side supplies requests and consumes results; the slave side is the encoder.
interface rr_priority_encoder_if #(
    parameter int N = 8
);
    localparam int W = $clog2(N);

    logic [N-1:0] req;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_index;
    logic [N-1:0] out_onehot;
    logic         out_multi;

    modport master (
        output req,
        output out_ready,
        input  out_valid,
        input  out_index,
        input  out_onehot,
        input  out_multi
    );

    modport slave (
        input  req,
        input  out_ready,
        output out_valid,
        output out_index,
        output out_onehot,
        output out_multi
    );
endinterface

// File: rtl/rr_priority_encoder.sv
// Registered N-to-log2(N) priority encoder, fixed (MODE=0) or round-robin (MODE=1),
// with a single output slot behind a valid/ready handshake.
module rr_priority_encoder #(
    parameter int N    = 8,
    parameter int MODE = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    rr_priority_encoder_if.slave    bus
);
    localparam int           W   = $clog2(N);
    localparam logic [N-1:0] ONE = N'(1);
    localparam logic [W-1:0] LAST = W'(N - 1);

    function automatic logic [W-1:0] highest_set(input logic [N-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) r = W'(i);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] lowest_set(input logic [N-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) r = W'(i);
        end
        return r;
    endfunction

    function automatic logic [N-1:0] at_or_above(input logic [W-1:0] p);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            r[i] = (i >= int'(p));
        end
        return r;
    endfunction

    // Search from p upward; if nothing at or above p, wrap and take the lowest request.
    function automatic logic [W-1:0] rr_select(input logic [N-1:0] v, input logic [W-1:0] p);
        logic [N-1:0] upper;
        upper = v & at_or_above(p);
        return (|upper) ? lowest_set(upper) : lowest_set(v);
    endfunction

    function automatic logic [N-1:0] decode(input logic [W-1:0] idx);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            r[i] = (int'(idx) == i);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] next_ptr(input logic [W-1:0] idx);
        return (idx == LAST) ? '0 : idx + W'(1);
    endfunction

    logic         out_valid_q,  out_valid_d;
    logic [W-1:0] out_index_q,  out_index_d;
    logic [N-1:0] out_onehot_q, out_onehot_d;
    logic         out_multi_q,  out_multi_d;

    logic         load;
    logic         handshake;
    logic [W-1:0] ptr_eff;
    logic [W-1:0] sel_idx;

    assign load      = !out_valid_q || bus.out_ready;
    assign handshake = out_valid_q && bus.out_ready;

    generate
        if (MODE == 1) begin : g_rr
            logic [W-1:0] ptr_q, ptr_d;

            // The pointer moves only on a handshake; the same-cycle reload sees the new value.
            always_comb begin
                ptr_d = ptr_q;
                if (handshake) ptr_d = next_ptr(out_index_q);
            end

            always_ff @(posedge clk) begin
                if (rst) ptr_q <= '0;
                else     ptr_q <= ptr_d;
            end

            assign ptr_eff = ptr_d;
        end else begin : g_fixed
            assign ptr_eff = '0;
        end
    endgenerate

    always_comb begin
        sel_idx      = (MODE == 1) ? rr_select(bus.req, ptr_eff) : highest_set(bus.req);
        out_valid_d  = 1'b0;
        out_index_d  = '0;
        out_onehot_d = '0;
        out_multi_d  = 1'b0;
        if (|bus.req) begin
            out_valid_d  = 1'b1;
            out_index_d  = sel_idx;
            out_onehot_d = decode(sel_idx);
            out_multi_d  = (bus.req & (bus.req - ONE)) != '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_index_q  <= '0;
            out_onehot_q <= '0;
            out_multi_q  <= 1'b0;
        end else if (load) begin
            out_valid_q  <= out_valid_d;
            out_index_q  <= out_index_d;
            out_onehot_q <= out_onehot_d;
            out_multi_q  <= out_multi_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_index  = out_index_q;
    assign bus.out_onehot = out_onehot_q;
    assign bus.out_multi  = out_multi_q;
endmodule

// File: tb/tb_rr_priority_encoder.sv
// Bench for rr_priority_encoder: three instances (N=8 fixed, N=8 round-robin, N=5 round-robin)
// driven by directed vectors, with expected results queued and checked by a monitor.
module tb_rr_priority_encoder;
    typedef struct {
        bit         v;
        int         idx;
        logic [7:0] oh;
        bit         m;
        string      nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    rr_priority_encoder_if #(.N(8)) if0 ();
    rr_priority_encoder_if #(.N(8)) if1 ();
    rr_priority_encoder_if #(.N(5)) if2 ();

    rr_priority_encoder #(.N(8), .MODE(0)) u0 (.clk(clk), .rst(rst), .bus(if0));
    rr_priority_encoder #(.N(8), .MODE(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
    rr_priority_encoder #(.N(5), .MODE(1)) u2 (.clk(clk), .rst(rst), .bus(if2));

    function automatic exp_t mk(input bit v, input int idx, input logic [7:0] oh, input bit m,
                                input string nm);
        exp_t e;
        e.v = v; e.idx = idx; e.oh = oh; e.m = m; e.nm = nm;
        return e;
    endfunction

    task automatic chk(input string dn, input exp_t e, input logic v, input logic [7:0] idx,
                       input logic [7:0] oh, input logic m);
        checks++;
        if (v !== e.v || idx !== 8'(e.idx) || oh !== e.oh || m !== e.m) begin
            errors++;
            $display("FAIL %s/%s: got valid=%0b index=%0d onehot=%h multi=%0b, want valid=%0b index=%0d onehot=%h multi=%0b",
                     dn, e.nm, v, idx, oh, m, e.v, e.idx, e.oh, e.m);
        end
    endtask

    // Drive one instance, let one edge pass, then queue what that edge must produce.
    task automatic step(input int d, input logic [7:0] r, input bit rdy, input bit rs, input exp_t e);
        rst = rs;
        case (d)
            0: begin if0.req = r; if0.out_ready = rdy; end
            1: begin if1.req = r; if1.out_ready = rdy; end
            default: begin if2.req = r[4:0]; if2.out_ready = rdy; end
        endcase
        @(posedge clk);
        case (d)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("u0", e, if0.out_valid, 8'(if0.out_index), if0.out_onehot, if0.out_multi);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("u1", e, if1.out_valid, 8'(if1.out_index), if1.out_onehot, if1.out_multi);
        end
        if (q2.size() > 0) begin
            e = q2.pop_front();
            chk("u2", e, if2.out_valid, 8'(if2.out_index), 8'(if2.out_onehot), if2.out_multi);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        if0.req = 8'hFF; if0.out_ready = 1'b1;
        if1.req = 8'h00; if1.out_ready = 1'b1;
        if2.req = 5'h00; if2.out_ready = 1'b1;

        // Reset, then first load after release
        step(0, 8'hFF, 1, 1, mk(0, 0, 8'h00, 0, "reset_a"));
        step(0, 8'hFF, 1, 1, mk(0, 0, 8'h00, 0, "reset_b"));
        step(0, 8'hFF, 1, 0, mk(1, 7, 8'h80, 1, "release"));

        // Fixed priority: empty, walking one, all-ones
        step(0, 8'h00, 1, 0, mk(0, 0, 8'h00, 0, "empty"));
        for (int i = 0; i < 8; i++) begin
            logic [7:0] w;
            w = 8'h01 << i;
            step(0, w, 1, 0, mk(1, i, w, 0, "walk"));
        end
        step(0, 8'hFF, 1, 0, mk(1, 7, 8'h80, 1, "all_ones"));

        // Backpressure
        step(0, 8'h00, 1, 0, mk(0, 0, 8'h00, 0, "bp_drain"));
        step(0, 8'h08, 0, 0, mk(1, 3, 8'h08, 0, "bp_load"));
        for (int i = 0; i < 5; i++) step(0, 8'h10, 0, 0, mk(1, 3, 8'h08, 0, "bp_hold"));
        step(0, 8'h10, 1, 0, mk(1, 4, 8'h10, 0, "bp_release"));

        // Round-robin rotation over all requests
        for (int k = 0; k < 10; k++) begin
            logic [7:0] w;
            w = 8'h01 << (k % 8);
            step(1, 8'hFF, 1, 0, mk(1, k % 8, w, 1, "rotate"));
        end

        // Round-robin wrap, sparse requests, empty slot leaves pointer alone
        step(1, 8'h00, 1, 0, mk(0, 0, 8'h00, 0, "rr_empty"));
        step(1, 8'h81, 1, 0, mk(1, 7, 8'h80, 1, "wrap_a"));
        step(1, 8'h81, 1, 0, mk(1, 0, 8'h01, 1, "wrap_b"));
        step(1, 8'h81, 1, 0, mk(1, 7, 8'h80, 1, "wrap_c"));
        step(1, 8'h81, 1, 0, mk(1, 0, 8'h01, 1, "wrap_d"));
        step(1, 8'h00, 1, 0, mk(0, 0, 8'h00, 0, "drop_a"));
        step(1, 8'h00, 1, 0, mk(0, 0, 8'h00, 0, "drop_b"));
        step(1, 8'h03, 1, 0, mk(1, 1, 8'h02, 1, "ptr_kept"));
        step(1, 8'h02, 1, 0, mk(1, 1, 8'h02, 0, "wrap_single"));
        step(1, 8'h00, 1, 0, mk(0, 0, 8'h00, 0, "rr_idle"));

        // Non-power-of-two width
        for (int k = 0; k < 6; k++) begin
            logic [7:0] w;
            w = 8'h01 << (k % 5);
            step(2, 8'h1F, 1, 0, mk(1, k % 5, w, 1, "n5_rotate"));
        end
        step(2, 8'h00, 1, 0, mk(0, 0, 8'h00, 0, "n5_empty"));

        // Reset in the middle of a stall clears the pointer too
        step(1, 8'hFF, 1, 0, mk(1, 2, 8'h04, 1, "adv_2"));
        step(1, 8'hFF, 1, 0, mk(1, 3, 8'h08, 1, "adv_3"));
        step(1, 8'hFF, 1, 0, mk(1, 4, 8'h10, 1, "adv_4"));
        step(1, 8'hFF, 1, 0, mk(1, 5, 8'h20, 1, "adv_5"));
        step(1, 8'hFF, 0, 0, mk(1, 5, 8'h20, 1, "stall"));
        step(1, 8'hFF, 0, 1, mk(0, 0, 8'h00, 0, "stall_reset"));
        step(1, 8'hFF, 1, 0, mk(1, 0, 8'h01, 1, "after_reset"));

        @(negedge clk);
        #1;
        if (q0.size() + q1.size() + q2.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0",
                     q0.size() + q1.size() + q2.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
